// File: rtl/rtc_bus_responder.sv
// RTC chip stand-in on the multiplexed address/data bus: latches the
// address phase, commits writes to a small register file and serves reads.
module rtc_bus_responder #(
    parameter int DW   = 8,
    parameter int NREG = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cs_n,
    input  logic          rd_n,
    input  logic          wr_n,
    input  logic          ad_n,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out,
    output logic          data_oe,
    output logic          wr_done,
    output logic          rd_done,
    output logic          proto_err,
    output logic [7:0]    err_count,
    output logic [DW-1:0] addr_q
);

    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [DW-1:0] LP_NREG = DW'(NREG);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WR   = 2'd1;
    localparam logic [1:0] ST_RD   = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    logic          r_s_cs_n;
    logic          r_s_rd_n;
    logic          r_s_wr_n;
    logic          r_s_ad_n;
    logic [DW-1:0] r_s_data;

    logic [1:0]    r_state;
    logic          r_kind;
    logic [DW-1:0] r_hold;
    logic [DW-1:0] r_addr;
    logic [DW-1:0] r_dout;
    logic          r_wr_done;
    logic          r_rd_done;
    logic [7:0]    r_err_cnt;
    logic [DW-1:0] r_regs [NREG];

    logic [1:0]    w_next;
    logic          w_wr_start;
    logic          w_wr_hold;
    logic          w_commit;
    logic          w_rd_start;
    logic          w_rd_fin;
    logic          w_err_enter;
    logic          w_addr_ok;
    logic [AW-1:0] w_idx;
    logic [DW-1:0] w_rd_data;

    assign w_addr_ok = (r_addr < LP_NREG);
    assign w_idx     = r_addr[AW-1:0];
    assign w_rd_data = w_addr_ok ? r_regs[w_idx] : '0;

    always_comb begin
        w_next     = r_state;
        w_wr_start = 1'b0;
        w_wr_hold  = 1'b0;
        w_commit   = 1'b0;
        w_rd_start = 1'b0;
        w_rd_fin   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (!r_s_cs_n) begin
                    if (!r_s_wr_n && r_s_rd_n) begin
                        w_next     = ST_WR;
                        w_wr_start = 1'b1;
                    end else if (!r_s_rd_n && r_s_wr_n && r_s_ad_n) begin
                        w_next     = ST_RD;
                        w_rd_start = 1'b1;
                    end else if (!r_s_rd_n) begin
                        w_next = ST_ERR;
                    end
                end
            end
            ST_WR: begin
                // Deselect wins over everything else: an aborted write never commits.
                if (r_s_cs_n) begin
                    w_next = ST_IDLE;
                end else if (!r_s_rd_n) begin
                    w_next = ST_ERR;
                end else if (r_s_wr_n) begin
                    w_next   = ST_IDLE;
                    w_commit = 1'b1;
                end else begin
                    w_wr_hold = 1'b1;
                end
            end
            ST_RD: begin
                if (r_s_cs_n) begin
                    w_next = ST_IDLE;
                end else if (!r_s_wr_n) begin
                    w_next = ST_ERR;
                end else if (r_s_rd_n) begin
                    w_next   = ST_IDLE;
                    w_rd_fin = 1'b1;
                end
            end
            ST_ERR: begin
                if (r_s_cs_n && r_s_rd_n && r_s_wr_n) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_err_enter = (w_next == ST_ERR) && (r_state != ST_ERR);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s_cs_n  <= 1'b1;
            r_s_rd_n  <= 1'b1;
            r_s_wr_n  <= 1'b1;
            r_s_ad_n  <= 1'b1;
            r_s_data  <= '0;
            r_state   <= ST_IDLE;
            r_kind    <= 1'b0;
            r_hold    <= '0;
            r_addr    <= '0;
            r_dout    <= '0;
            r_wr_done <= 1'b0;
            r_rd_done <= 1'b0;
            r_err_cnt <= '0;
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_s_cs_n  <= cs_n;
            r_s_rd_n  <= rd_n;
            r_s_wr_n  <= wr_n;
            r_s_ad_n  <= ad_n;
            r_s_data  <= data_in;
            r_state   <= w_next;
            r_wr_done <= w_commit;
            r_rd_done <= w_rd_fin;
            if (w_wr_start) begin
                r_kind <= r_s_ad_n;
                r_hold <= r_s_data;
            end else if (w_wr_hold) begin
                r_hold <= r_s_data;
            end
            if (w_commit) begin
                if (!r_kind) begin
                    r_addr <= r_hold;
                end else if (w_addr_ok) begin
                    r_regs[w_idx] <= r_hold;
                end
            end
            if (w_rd_start) begin
                r_dout <= w_rd_data;
            end
            if (w_err_enter && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign data_out  = r_dout;
    assign data_oe   = (r_state == ST_RD);
    assign wr_done   = r_wr_done;
    assign rd_done   = r_rd_done;
    assign proto_err = (r_state == ST_ERR);
    assign err_count = r_err_cnt;
    assign addr_q    = r_addr;

endmodule
